// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         CNT_W_DEF    = 16;
  localparam int         WAIT_MAX_DEF = 15;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic freeze;
  } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               count <= '0;
    else if (clr)                          count <= '0;
    else if (inc && (count != {W{1'b1}}))  count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze,
// taken-branch flush (resolved in MEM) and load-use bubble, plus perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IFID_Rs_in,
  input  logic [4:0]       IFID_Rt_in,
  input  logic             IFID_UsesRt_in,
  input  logic             IDEX_MemRead_in,
  input  logic [4:0]       IDEX_Rt_in,
  input  logic             EXMEM_Branch_in,
  input  logic             EXMEM_Zero_in,
  input  logic             EXMEM_MemRead_in,
  input  logic             EXMEM_MemWrite_in,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             Freeze,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e     state, state_nxt;
  logic [7:0] wait_cnt;
  ctrl_t      ctrl;
  logic       mem_access, taken, lu, lu_stall, mem_stall;

  always_comb begin
    mem_access = EXMEM_MemRead_in | EXMEM_MemWrite_in;
    taken      = EXMEM_Branch_in & EXMEM_Zero_in;
    lu         = IDEX_MemRead_in && (IDEX_Rt_in != REG_ZERO) &&
                 ((IDEX_Rt_in == IFID_Rs_in) ||
                  (IFID_UsesRt_in && (IDEX_Rt_in == IFID_Rt_in)));

    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      RUN: begin
        mem_stall = mem_access & ~dmem_ready;
        if (mem_stall) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_stall = ~dmem_ready;
        if (dmem_ready) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase

    // Priority: memory freeze > taken branch > load-use bubble.
    lu_stall        = 1'b0;
    ctrl            = '0;
    ctrl.pc_write   = 1'b1;
    ctrl.ifid_write = 1'b1;
    if (mem_stall) begin
      ctrl.freeze     = 1'b1;
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
    end else if (taken) begin
      ctrl.pc_src      = 1'b1;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (lu) begin
      lu_stall        = 1'b1;
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      ctrl.idex_flush = 1'b1;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCSrc       = ctrl.pc_src;
  assign IFID_Write  = ctrl.ifid_write;
  assign IFID_Flush  = ctrl.ifid_flush;
  assign IDEX_Flush  = ctrl.idex_flush;
  assign EXMEM_Flush = ctrl.exmem_flush;
  assign Freeze      = ctrl.freeze;
  assign dmem_req    = mem_access;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Timeout is only flagged; the FSM keeps waiting for the memory.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (state == MEM_WAIT && !dmem_ready) begin
      if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      if (int'(wait_cnt) + 1 >= WAIT_MAX) mem_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(Clk), .rst(Rst), .inc(ctrl.freeze | lu_stall), .clr(1'b0), .count(stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(Clk), .rst(Rst), .inc(taken & ~mem_stall), .clr(1'b0), .count(flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int WMAX = 15;

  logic       Clk = 1'b0, Rst = 1'b0;
  logic [4:0] rs, rt, ldrt;
  logic       usesrt, ldr, br, z, mr, mw, rdy;

  logic        PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Freeze, dmem_req, mem_err;
  logic [15:0] stall_cycles, flush_count;
  logic        s_PCWrite, s_PCSrc, s_IFID_Write, s_IFID_Flush, s_IDEX_Flush, s_EXMEM_Flush, s_Freeze, s_dmem_req, s_mem_err;
  logic [3:0]  s_stall, s_flush;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.CNT_W(16), .WAIT_MAX(WMAX)) dut (
    .Clk(Clk), .Rst(Rst), .IFID_Rs_in(rs), .IFID_Rt_in(rt), .IFID_UsesRt_in(usesrt),
    .IDEX_MemRead_in(ldr), .IDEX_Rt_in(ldrt), .EXMEM_Branch_in(br), .EXMEM_Zero_in(z),
    .EXMEM_MemRead_in(mr), .EXMEM_MemWrite_in(mw), .dmem_ready(rdy),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .Freeze(Freeze), .dmem_req(dmem_req),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .WAIT_MAX(WMAX)) dut4 (
    .Clk(Clk), .Rst(Rst), .IFID_Rs_in(rs), .IFID_Rt_in(rt), .IFID_UsesRt_in(usesrt),
    .IDEX_MemRead_in(ldr), .IDEX_Rt_in(ldrt), .EXMEM_Branch_in(br), .EXMEM_Zero_in(z),
    .EXMEM_MemRead_in(mr), .EXMEM_MemWrite_in(mw), .dmem_ready(rdy),
    .PCWrite(s_PCWrite), .PCSrc(s_PCSrc), .IFID_Write(s_IFID_Write), .IFID_Flush(s_IFID_Flush),
    .IDEX_Flush(s_IDEX_Flush), .EXMEM_Flush(s_EXMEM_Flush), .Freeze(s_Freeze), .dmem_req(s_dmem_req),
    .mem_err(s_mem_err), .stall_cycles(s_stall), .flush_count(s_flush)
  );

  logic [7:0] obs, obs4;
  assign obs  = {PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Freeze, dmem_req};
  assign obs4 = {s_PCWrite, s_PCSrc, s_IFID_Write, s_IFID_Flush, s_IDEX_Flush, s_EXMEM_Flush, s_Freeze, s_dmem_req};

  int vectors = 0, miscompares = 0;

  // Behavioural model: "waiting on memory" flag, wait length, sticky error, plain integer counters.
  bit m_wait, m_err;
  int m_wcnt, m_stall, m_flush, m_stall4, m_flush4;

  function automatic bit lu_hit();
    return ldr && (ldrt != 0) && ((ldrt == rs) || (usesrt && (ldrt == rt)));
  endfunction

  function automatic bit mem_blocked();
    return m_wait ? !rdy : ((mr || mw) && !rdy);
  endfunction

  // {PCWrite,PCSrc,IFID_Write,IFID_Flush,IDEX_Flush,EXMEM_Flush,Freeze,dmem_req}
  function automatic logic [7:0] exp_ctrl();
    logic req;
    req = mr | mw;
    if (mem_blocked())  return {7'b0000001, req};
    if (br && z)        return {7'b1111110, req};
    if (lu_hit())       return {7'b0000100, req};
    return {7'b1010000, req};
  endfunction

  task automatic model_reset();
    m_wait = 0; m_err = 0; m_wcnt = 0;
    m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
  endtask

  task automatic model_update();
    bit blk, tk;
    blk = mem_blocked();
    tk  = br && z;
    if (blk || (!tk && lu_hit())) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall4 < 15)   m_stall4++;
    end
    if (!blk && tk) begin
      if (m_flush < 65535) m_flush++;
      if (m_flush4 < 15)   m_flush4++;
    end
    if (m_wait) begin
      if (rdy) begin m_wait = 0; m_wcnt = 0; end
      else begin
        m_wcnt++;
        if (m_wcnt >= WMAX) m_err = 1;
      end
    end else if ((mr || mw) && !rdy) m_wait = 1;
  endtask

  // Inputs change at posedge+1; combinational checks happen at posedge+4.
  task automatic tick();
    @(posedge Clk);
    if (!Rst) model_update();
    #1;
  endtask

  task automatic set_idle();
    rs = 0; rt = 0; usesrt = 0; ldr = 0; ldrt = 0; br = 0; z = 0; mr = 0; mw = 0; rdy = 0;
  endtask

  task automatic hard_reset();
    #1 Rst = 1'b1;
    model_reset();
    @(posedge Clk); #1 Rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    #2 Rst = 1'b1;
    #1;
    vectors++; if (obs !== 8'b10100000) begin miscompares++; $display("FAIL reset_ctrl: got %b want %b", obs, 8'b10100000); end
    vectors++; if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    vectors++; if (flush_count !== 16'd0) begin miscompares++; $display("FAIL reset_flush: got %0d want 0", flush_count); end
    vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", mem_err); end
    model_reset();
    @(posedge Clk); #1 Rst = 1'b0;
  endtask

  task automatic test_load_use();
    set_idle(); ldr = 1; ldrt = 8; rs = 8; #3;
    vectors++; if (obs !== 8'b00001000) begin miscompares++; $display("FAIL lu_rs_ctrl: got %b want %b", obs, 8'b00001000); end
    tick(); set_idle();
    vectors++; if (stall_cycles !== 16'(m_stall) || m_stall != 1) begin miscompares++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cycles); end
    ldr = 1; ldrt = 0; rs = 0; #3;
    vectors++; if (obs !== 8'b10100000) begin miscompares++; $display("FAIL lu_r0_ctrl: got %b want %b", obs, 8'b10100000); end
    tick();
    vectors++; if (stall_cycles !== 16'(m_stall)) begin miscompares++; $display("FAIL lu_r0_cnt: got %0d want %0d", stall_cycles, m_stall); end
    set_idle(); ldr = 1; ldrt = 9; rt = 9; rs = 3; usesrt = 1; #3;
    vectors++; if (obs !== exp_ctrl()) begin miscompares++; $display("FAIL lu_rt_ctrl: got %b want %b", obs, exp_ctrl()); end
    tick(); usesrt = 0; #3;
    vectors++; if (obs !== exp_ctrl()) begin miscompares++; $display("FAIL lu_rt_unused_ctrl: got %b want %b", obs, exp_ctrl()); end
    tick(); set_idle();
  endtask

  task automatic test_branch();
    set_idle(); br = 1; z = 1; ldr = 1; ldrt = 8; rs = 8; #3;
    vectors++; if (obs !== 8'b11111100) begin miscompares++; $display("FAIL br_ctrl: got %b want %b", obs, 8'b11111100); end
    tick(); set_idle();
    vectors++; if (flush_count !== 16'(m_flush) || m_flush != 1) begin miscompares++; $display("FAIL br_flush_cnt: got %0d want 1", flush_count); end
    vectors++; if (stall_cycles !== 16'(m_stall)) begin miscompares++; $display("FAIL br_no_stall: got %0d want %0d", stall_cycles, m_stall); end
    br = 1; z = 0; ldr = 1; ldrt = 4; rs = 4; #3;
    vectors++; if (obs !== 8'b00001000) begin miscompares++; $display("FAIL br_not_taken: got %b want %b", obs, 8'b00001000); end
    tick(); set_idle();
  endtask

  task automatic test_mem_wait();
    set_idle(); mr = 1;
    for (int i = 0; i < 3; i++) begin
      #3;
      vectors++; if (obs !== 8'b00000011) begin miscompares++; $display("FAIL wait_freeze[%0d]: got %b want %b", i, obs, 8'b00000011); end
      tick();
    end
    rdy = 1; #3;
    vectors++; if (obs !== 8'b10100001) begin miscompares++; $display("FAIL wait_release: got %b want %b", obs, 8'b10100001); end
    tick(); set_idle(); #3;
    vectors++; if (obs !== 8'b10100000) begin miscompares++; $display("FAIL wait_back_run: got %b want %b", obs, 8'b10100000); end
    vectors++; if (stall_cycles !== 16'(m_stall)) begin miscompares++; $display("FAIL wait_stall_cnt: got %0d want %0d", stall_cycles, m_stall); end
    tick();
    mw = 1; rdy = 1; #3;
    vectors++; if (obs !== 8'b10100001) begin miscompares++; $display("FAIL zero_wait: got %b want %b", obs, 8'b10100001); end
    tick(); set_idle(); #3;
    vectors++; if (Freeze !== 1'b0) begin miscompares++; $display("FAIL zero_wait_run: got %b want 0", Freeze); end
    vectors++; if (stall_cycles !== 16'(m_stall)) begin miscompares++; $display("FAIL zero_wait_cnt: got %0d want %0d", stall_cycles, m_stall); end
    tick();
  endtask

  task automatic test_timeout();
    set_idle(); mw = 1;
    for (int i = 0; i < WMAX + 2; i++) begin
      tick();
      vectors++; if (mem_err !== m_err) begin miscompares++; $display("FAIL timeout_err[%0d]: got %b want %b", i, mem_err, m_err); end
    end
    rdy = 1; tick(); set_idle();
    vectors++; if (mem_err !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b want 1", mem_err); end
    mw = 1; tick(); tick();
    Rst = 1'b1; mw = 0; model_reset(); #1;
    vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL rst_clears_err: got %b want 0", mem_err); end
    vectors++; if (obs !== 8'b10100000) begin miscompares++; $display("FAIL rst_to_run: got %b want %b", obs, 8'b10100000); end
    tick(); Rst = 1'b0;
  endtask

  task automatic test_saturation();
    set_idle(); hard_reset();
    br = 1; z = 1;
    for (int i = 0; i < 20; i++) tick();
    set_idle();
    vectors++; if (s_flush !== 4'd15) begin miscompares++; $display("FAIL sat_flush4: got %0d want 15", s_flush); end
    vectors++; if (flush_count !== 16'(m_flush)) begin miscompares++; $display("FAIL sat_flush16: got %0d want %0d", flush_count, m_flush); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); ldrt = 5'($urandom_range(0, 3));
      usesrt = 1'($urandom); ldr = 1'($urandom); z = 1'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      if (!m_wait) begin
        br = 1'($urandom); mr = 0; mw = 0;
        if (!br && $urandom_range(0, 1) == 1) begin mr = 1'($urandom); mw = !mr; end
      end
      #3;
      vectors++; if (obs !== exp_ctrl()) begin miscompares++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i, obs, exp_ctrl()); end
      vectors++; if (obs4 !== exp_ctrl()) begin miscompares++; $display("FAIL rnd_ctrl4[%0d]: got %b want %b", i, obs4, exp_ctrl()); end
      tick();
      vectors++; if (stall_cycles !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
        miscompares++; $display("FAIL rnd_cnt16[%0d]: got %0d/%0d want %0d/%0d", i, stall_cycles, flush_count, m_stall, m_flush); end
      vectors++; if (s_stall !== 4'(m_stall4) || s_flush !== 4'(m_flush4)) begin
        miscompares++; $display("FAIL rnd_cnt4[%0d]: got %0d/%0d want %0d/%0d", i, s_stall, s_flush, m_stall4, m_flush4); end
      vectors++; if (mem_err !== m_err || s_mem_err !== m_err) begin
        miscompares++; $display("FAIL rnd_err[%0d]: got %b/%b want %b", i, mem_err, s_mem_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
